// File: rtl/ads_frame_reader.sv
// ADS1298 read-data engine: waits for DRDY, clocks out one status + NUM_CH channel words over SPI,
// and streams them through a small FIFO. Define ADS_STATUS_CHECK_EN to drop frames with a bad status nibble.
module ads_frame_reader #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned WORD_BITS  = 24,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CS_GUARD   = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 enable,
  input  logic                 drdy_n,
  input  logic                 spi_dout,
  output logic                 spi_sclk,
  output logic                 spi_cs_n,
  output logic [WORD_BITS-1:0] m_tdata,
  output logic [3:0]           m_tuser,
  output logic                 m_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 clr_overrun,
`ifdef ADS_STATUS_CHECK_EN
  output logic                 status_err,
`endif
  output logic [31:0]          frame_cnt
);

  localparam int unsigned TOTAL_BITS = (NUM_CH + 1) * WORD_BITS;
  localparam int unsigned BIT_W      = $clog2(TOTAL_BITS + 1);
  localparam int unsigned PH_W       = $clog2(2 * CLK_DIV + CS_GUARD + 1);
  localparam int unsigned WB_W       = $clog2(WORD_BITS + 1);
  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam int unsigned CW         = AW + 1;
  localparam int unsigned ENT_W      = WORD_BITS + 5;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_drdy_sync, r_dout_sync;
  logic                 r_drdy_prev;
  logic [PH_W-1:0]      r_cnt;
  logic [BIT_W-1:0]     r_bit;
  logic [WB_W-1:0]      r_wbit;
  logic [3:0]           r_widx;
  logic [WORD_BITS-2:0] r_shreg;
  logic                 r_bad, r_push;
  logic [ENT_W-1:0]     r_push_ent;
  logic [ENT_W-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_mcount;

  logic w_drdy_evt, w_bit_end, w_guard_end, w_last_bit;
  logic w_cs_n_nxt, w_sclk_nxt, w_sample, w_frame_done, w_start;
  logic w_word_done, w_status_bad;
  logic [WORD_BITS-1:0] w_word;
  logic w_pop, w_full, w_push_ok, w_drop, w_out_free, w_mem_rd, w_bypass, w_mem_wr;

  // 2-FF synchronisers; DRDY idles high so reset to 1 to avoid a false edge
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_drdy_sync <= 2'b11;
      r_drdy_prev <= 1'b1;
      r_dout_sync <= 2'b00;
    end else begin
      r_drdy_sync <= {r_drdy_sync[0], drdy_n};
      r_drdy_prev <= r_drdy_sync[1];
      r_dout_sync <= {r_dout_sync[0], spi_dout};
    end
  end

  assign w_drdy_evt  = r_drdy_prev & ~r_drdy_sync[1];
  assign w_bit_end   = (r_cnt == PH_W'(2 * CLK_DIV - 1));
  assign w_guard_end = (r_cnt == PH_W'(CS_GUARD - 1));
  assign w_last_bit  = (r_bit == BIT_W'(TOTAL_BITS - 1));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_drdy_evt && enable)     w_state_nxt = S_SETUP;
      S_SETUP: if (w_guard_end)              w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_bit_end && w_last_bit)  w_state_nxt = S_HOLD;
      S_HOLD:  if (w_guard_end)              w_state_nxt = S_IDLE;
      default:                               w_state_nxt = S_IDLE;
    endcase
  end

  // SCLK is high for the second half of each bit; data is taken in the cycle it falls
  always_comb begin
    w_cs_n_nxt   = (w_state_nxt == S_IDLE);
    w_sclk_nxt   = (r_state == S_SHIFT) && (r_cnt >= PH_W'(CLK_DIV - 1)) &&
                   (r_cnt < PH_W'(2 * CLK_DIV - 1));
    w_sample     = (r_state == S_SHIFT) && w_bit_end;
    w_frame_done = (r_state == S_HOLD) && w_guard_end;
    w_start      = (r_state == S_IDLE) && (w_state_nxt == S_SETUP);
  end

  assign w_word      = {r_shreg, r_dout_sync[1]};
  assign w_word_done = w_sample && (r_wbit == WB_W'(WORD_BITS - 1));

`ifdef ADS_STATUS_CHECK_EN
  assign w_status_bad = w_word_done && (r_widx == 4'd0) &&
                        (w_word[WORD_BITS-1 -: 4] != 4'b1100);
`else
  assign w_status_bad = 1'b0;
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_cnt      <= '0;
      r_bit      <= '0;
      r_wbit     <= '0;
      r_widx     <= '0;
      r_shreg    <= '0;
      r_bad      <= 1'b0;
      r_push     <= 1'b0;
      r_push_ent <= '0;
      spi_sclk   <= 1'b0;
      spi_cs_n   <= 1'b1;
      busy       <= 1'b0;
      frame_cnt  <= '0;
`ifdef ADS_STATUS_CHECK_EN
      status_err <= 1'b0;
`endif
    end else begin
      if ((r_state != w_state_nxt) || w_sample) r_cnt <= '0;
      else if (r_state != S_IDLE)               r_cnt <= r_cnt + PH_W'(1);
      if (w_start) begin
        r_bit  <= '0;
        r_wbit <= '0;
        r_widx <= '0;
        r_bad  <= 1'b0;
      end else if (w_sample) begin
        r_shreg <= w_word[WORD_BITS-2:0];
        r_bit   <= r_bit + BIT_W'(1);
        if (w_word_done) begin
          r_wbit <= '0;
          r_widx <= r_widx + 4'd1;
        end else begin
          r_wbit <= r_wbit + WB_W'(1);
        end
        if (w_status_bad) r_bad <= 1'b1;
      end
      r_push <= w_word_done && !r_bad && !w_status_bad;
      if (w_word_done) r_push_ent <= {(r_widx == 4'(NUM_CH)), r_widx, w_word};
      spi_sclk <= w_sclk_nxt;
      spi_cs_n <= w_cs_n_nxt;
      busy     <= (w_state_nxt != S_IDLE);
      if (w_frame_done) frame_cnt <= frame_cnt + 32'd1;
`ifdef ADS_STATUS_CHECK_EN
      status_err <= w_status_bad;
`endif
    end
  end

  // Output register is the FIFO head; the memory holds the other FIFO_DEPTH-1 entries
  assign w_pop      = m_tvalid & m_tready;
  assign w_full     = m_tvalid && (r_mcount == CW'(FIFO_DEPTH - 1));
  assign w_push_ok  = r_push && (!w_full || w_pop);
  assign w_drop     = r_push && !w_push_ok;
  assign w_out_free = !m_tvalid || w_pop;
  assign w_mem_rd   = w_out_free && (r_mcount != '0);
  assign w_bypass   = w_out_free && (r_mcount == '0) && w_push_ok;
  assign w_mem_wr   = w_push_ok && !w_bypass;

  always_ff @(posedge ACLK) begin
    if (w_mem_wr) r_mem[r_wr_ptr] <= r_push_ent;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_mcount <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tuser  <= '0;
      m_tlast  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (w_mem_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_mem_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_mem_wr, w_mem_rd})
        2'b10:   r_mcount <= r_mcount + CW'(1);
        2'b01:   r_mcount <= r_mcount - CW'(1);
        default: r_mcount <= r_mcount;
      endcase
      if (w_mem_rd) begin
        {m_tlast, m_tuser, m_tdata} <= r_mem[r_rd_ptr];
        m_tvalid <= 1'b1;
      end else if (w_bypass) begin
        {m_tlast, m_tuser, m_tdata} <= r_push_ent;
        m_tvalid <= 1'b1;
      end else if (w_out_free) begin
        m_tvalid <= 1'b0;
      end
      if (w_drop)           overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule
